// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the PS/2 lines,
// assembles start/8 data/odd parity/stop frames, and pulses rx_valid or rx_err per frame.
module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER_LEN - 1);
  // Firing one count early makes rx_err land TIMEOUT_CYCLES cycles after the last strobe.
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             filt_q, filt_d, filt_prev_q;
  logic [FiltW-1:0] fcnt_q, fcnt_d;
  logic             clk_s, data_s, strobe;

  state_e           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       sh_q, sh_d;
  logic             par_q, par_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             valid_q, valid_d, err_q, err_d;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign strobe = filt_prev_q & ~filt_q;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FiltMax) begin
        filt_d = clk_s;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    sh_d      = sh_q;
    par_d     = par_q;
    tmo_d     = '0;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (state_q != StIdle) tmo_d = tmo_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (strobe && !data_s) begin
          state_d  = StData;
          bitcnt_d = 3'd0;
        end
      end
      StData: begin
        if (strobe) begin
          sh_d     = {data_s, sh_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (strobe) begin
          par_d   = data_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (strobe) begin
          if (data_s && (^sh_q ^ par_q)) begin
            rx_data_d = sh_q;
            valid_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A strobe coinciding with expiry advances the frame instead of timing out.
    if (strobe) begin
      tmo_d = '0;
    end else if (state_q != StIdle && tmo_q == TmoLast) begin
      state_d = StIdle;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= StIdle;
      bitcnt_q    <= 3'd0;
      sh_q        <= 8'h00;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      rx_data_q   <= 8'h00;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      sh_q        <= sh_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      rx_data_q   <= rx_data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: directed PS/2 frames against a per-cycle
// expectation timeline built from the frame rules, plus literal spot checks.
module tb_ps2_rx_frame;
  localparam int F    = 8;
  localparam int T    = 300;
  localparam int H    = 40;
  localparam int MAXC = 20000;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, busy;

  ps2_rx_frame #(
    .FILTER_LEN    (F),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk     (clk),
    .clear   (clear),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         exp_valid [MAXC];
  bit         exp_err   [MAXC];
  bit         exp_busy  [MAXC];
  logic [7:0] exp_byte  [MAXC];
  logic [7:0] exp_data = 8'h00;

  int checks = 0, failures = 0;
  int nvalid = 0, nerr = 0;
  int last_err_cyc = -1, last_valid_cyc = -1, last_fe = -1;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (clear) begin
      exp_data = 8'h00;
    end else if (cyc < MAXC) begin
      if (exp_valid[cyc]) exp_data = exp_byte[cyc];
      chk("rx_valid", 32'(rx_valid), 32'(exp_valid[cyc]));
      chk("rx_err", 32'(rx_err), 32'(exp_err[cyc]));
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      chk("rx_data", 32'(rx_data), 32'(exp_data));
    end
    if (rx_valid) begin
      nvalid++;
      last_valid_cyc = cyc;
    end
    if (rx_err) begin
      nerr++;
      last_err_cyc = cyc;
    end
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic par, input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  // ending: 0 = complete frame, 1 = abandon and let it time out, 2 = abandon with clear
  task automatic send(input logic [10:0] bits, input int nb, input int glitch_bit,
                      input int ending);
    int c0;
    int sc[11];
    int end_c;
    logic [7:0] b;
    c0 = cyc;
    for (int i = 0; i < nb; i++) sc[i] = c0 + i * 2 * H + H / 2 + F + 2;
    if (bits[0] == 1'b0) begin
      if (nb == 11) begin
        b     = bits[8:1];
        end_c = sc[10] + 1;
        if (bits[10] && (^bits[9:1])) begin
          exp_valid[end_c] = 1'b1;
          exp_byte[end_c]  = b;
        end else begin
          exp_err[end_c] = 1'b1;
        end
      end else if (ending == 1) begin
        end_c = sc[nb-1] + T;
        exp_err[end_c] = 1'b1;
      end else begin
        end_c = c0 + nb * 2 * H + 10;
      end
      for (int c = sc[0] + 1; c < end_c; c++) exp_busy[c] = 1'b1;
    end
    for (int i = 0; i < nb; i++) begin
      ps2_data = bits[i];
      wait_cyc(H / 2);
      ps2_clk = 1'b0;
      last_fe = cyc;
      wait_cyc(H);
      ps2_clk = 1'b1;
      if (i == glitch_bit) begin
        wait_cyc(12);
        ps2_clk = 1'b0;
        wait_cyc(F - 2);
        ps2_clk = 1'b1;
        wait_cyc(H / 2 - 12 - (F - 2));
      end else begin
        wait_cyc(H / 2);
      end
    end
    ps2_data = 1'b1;
    if (ending == 1) begin
      wait_cyc(T + 20);
    end else if (ending == 2) begin
      wait_cyc(10);
      clear = 1'b1;
      #1;
      chk("clear_rx_data", 32'(rx_data), 0);
      chk("clear_rx_valid", 32'(rx_valid), 0);
      chk("clear_rx_err", 32'(rx_err), 0);
      chk("clear_busy", 32'(busy), 0);
      wait_cyc(1);
      clear = 1'b0;
      wait_cyc(5);
    end
  endtask

  initial begin
    wait_cyc(3);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_rx_err", 32'(rx_err), 0);
    chk("reset_busy", 32'(busy), 0);
    clear = 1'b0;
    wait_cyc(5);

    send(frame(8'h1C, 1'b0, 1'b1), 11, -1, 0);
    chk("good_1c_data", 32'(rx_data), 32'h1C);
    chk("valid_latency", last_valid_cyc - last_fe, F + 3);
    chk("idle_after_good", 32'(busy), 0);

    send(frame(8'hF0, 1'b1, 1'b1), 11, -1, 0);
    chk("b2b_f0_data", 32'(rx_data), 32'hF0);
    send(frame(8'h1C, 1'b0, 1'b1), 11, -1, 0);
    chk("b2b_1c_data", 32'(rx_data), 32'h1C);

    send(frame(8'h1C, 1'b1, 1'b1), 11, -1, 0);
    chk("bad_parity_hold", 32'(rx_data), 32'h1C);

    send(frame(8'h1C, 1'b0, 1'b0), 11, -1, 0);
    send(frame(8'hF0, 1'b1, 1'b1), 11, -1, 0);
    chk("after_bad_stop", 32'(rx_data), 32'hF0);

    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(F - 2);
    ps2_clk = 1'b1;
    wait_cyc(40);
    chk("idle_glitch_busy", 32'(busy), 0);

    send(frame(8'h5A, 1'b1, 1'b1), 11, 4, 0);
    chk("glitch_frame_data", 32'(rx_data), 32'h5A);

    send(frame(8'hFF, 1'b1, 1'b1), 6, -1, 1);
    chk("timeout_latency", last_err_cyc - last_fe, F + 2 + T);
    chk("timeout_idle", 32'(busy), 0);

    send(frame(8'h33, 1'b1, 1'b1), 4, -1, 2);
    send(frame(8'h1C, 1'b0, 1'b1), 11, -1, 0);
    chk("after_clear_data", 32'(rx_data), 32'h1C);

    wait_cyc(20);
    chk("valid_pulse_count", nvalid, 6);
    chk("err_pulse_count", nerr, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
